// File: rtl/flag_cycle_counter_mc.sv
// Multi-channel flag cycle counter: measures per-channel high time or rise-to-rise period with
// saturating counters, sticky done/overflow flags and a one-cycle registered read port.
module flag_cycle_counter_mc #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 33,
   parameter int unsigned EVT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SEL_W       = 4
) (
   input  logic              clock,
   input  logic              rstb,
   input  logic [NUM_CH-1:0] flag_in,
   input  logic [NUM_CH-1:0] mode,
   input  logic              clear,
   input  logic              rd_en,
   input  logic [SEL_W-1:0]  ch_sel,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic [EVT_W-1:0]  rd_evt,
   output logic [NUM_CH-1:0] done_mask,
   output logic [NUM_CH-1:0] ovf_mask
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NUM_CH-1:0] w_flag_s;

   // Synchronizer is deliberately outside the clear domain so in-flight edges survive clear.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_flag_s = flag_in;
      end else begin : g_sync
         logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
         always_ff @(posedge clock or negedge rstb) begin
            if (!rstb) begin
               for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
            end else begin
               r_sync[0] <= flag_in;
               for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
            end
         end
         assign w_flag_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   logic [NUM_CH-1:0] r_prev;
   logic [NUM_CH-1:0] r_armed;
   logic [NUM_CH-1:0] r_done;
   logic [NUM_CH-1:0] r_ovf;
   logic [CNT_W-1:0]  r_live [NUM_CH];
   logic [CNT_W-1:0]  r_cap  [NUM_CH];
   logic [EVT_W-1:0]  r_evt  [NUM_CH];

   logic [NUM_CH-1:0] w_armed_d;
   logic [NUM_CH-1:0] w_done_d;
   logic [NUM_CH-1:0] w_ovf_d;
   logic [CNT_W-1:0]  w_live_d [NUM_CH];
   logic [CNT_W-1:0]  w_cap_d  [NUM_CH];
   logic [EVT_W-1:0]  w_evt_d  [NUM_CH];

   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_fall;
   logic [NUM_CH-1:0] w_sel_hit;
   logic [NUM_CH-1:0] w_capture;
   logic [NUM_CH-1:0] w_inc;
   logic [CNT_W-1:0]  w_rd_data_mux;
   logic [EVT_W-1:0]  w_rd_evt_mux;

   assign done_mask = r_done;
   assign ovf_mask  = r_ovf;

   always_comb begin
      w_rise = w_flag_s & ~r_prev;
      w_fall = ~w_flag_s & r_prev;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         w_sel_hit[i] = (ch_sel == SEL_W'(i));
      end
   end

   // Out-of-range selects match no channel and read back as zero.
   always_comb begin
      w_rd_data_mux = '0;
      w_rd_evt_mux  = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (w_sel_hit[i]) begin
            w_rd_data_mux = r_cap[i];
            w_rd_evt_mux  = r_evt[i];
         end
      end
   end

   always_comb begin
      w_capture = '0;
      w_inc     = '0;
      w_armed_d = r_armed;
      w_done_d  = r_done;
      w_ovf_d   = r_ovf;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         w_live_d[i] = r_live[i];
         w_cap_d[i]  = r_cap[i];
         w_evt_d[i]  = r_evt[i];

         if (mode[i]) begin
            w_capture[i] = w_rise[i] & r_armed[i];
            w_inc[i]     = r_armed[i] & ~w_rise[i];
         end else begin
            w_capture[i] = w_fall[i];
            w_inc[i]     = w_flag_s[i];
         end

         if (w_inc[i]) begin
            if (r_live[i] == CNT_MAX) begin
               w_ovf_d[i] = 1'b1;
            end else begin
               w_live_d[i] = r_live[i] + CNT_W'(1);
            end
         end

         if (mode[i] && w_rise[i]) begin
            w_live_d[i]  = CNT_W'(1);
            w_armed_d[i] = 1'b1;
         end
         if (!mode[i] && w_fall[i]) begin
            w_live_d[i] = '0;
         end

         // A capture on the same edge as a read of this channel keeps done set.
         if (w_capture[i]) begin
            w_cap_d[i]  = r_live[i];
            w_evt_d[i]  = r_evt[i] + EVT_W'(1);
            w_done_d[i] = 1'b1;
         end else if (rd_en && w_sel_hit[i]) begin
            w_done_d[i] = 1'b0;
         end

         if (clear) begin
            w_live_d[i]  = '0;
            w_cap_d[i]   = '0;
            w_evt_d[i]   = '0;
            w_armed_d[i] = 1'b0;
            w_done_d[i]  = 1'b0;
            w_ovf_d[i]   = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge rstb) begin
      if (!rstb) begin
         r_prev   <= '0;
         r_armed  <= '0;
         r_done   <= '0;
         r_ovf    <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            r_live[i] <= '0;
            r_cap[i]  <= '0;
            r_evt[i]  <= '0;
         end
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_evt   <= '0;
      end else begin
         r_prev  <= w_flag_s;
         r_armed <= w_armed_d;
         r_done  <= w_done_d;
         r_ovf   <= w_ovf_d;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            r_live[i] <= w_live_d[i];
            r_cap[i]  <= w_cap_d[i];
            r_evt[i]  <= w_evt_d[i];
         end
         rd_valid <= rd_en;
         // Read samples pre-edge state, so a coincident clear or capture is not visible yet.
         if (rd_en) begin
            rd_data <= w_rd_data_mux;
            rd_evt  <= w_rd_evt_mux;
         end
      end
   end

endmodule

// File: tb/tb_flag_cycle_counter_mc.sv
// Bench for flag_cycle_counter_mc: episode-level reference model, vector table, corner sequences.
module tb_flag_cycle_counter_mc;

   localparam int unsigned NUM_CH      = 4;
   localparam int unsigned CNT_W       = 33;
   localparam int unsigned EVT_W       = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned SEL_W       = 4;
   localparam int unsigned SAT_W       = 4;
   localparam longint      CMAX        = (longint'(1) << CNT_W) - 1;

   logic              clock   = 1'b0;
   logic              rstb    = 1'b0;
   logic [NUM_CH-1:0] flag_in = '0;
   logic [NUM_CH-1:0] mode    = '0;
   logic              clear   = 1'b0;
   logic              rd_en   = 1'b0;
   logic [SEL_W-1:0]  ch_sel  = '0;

   logic              rd_valid;
   logic [CNT_W-1:0]  rd_data;
   logic [EVT_W-1:0]  rd_evt;
   logic [NUM_CH-1:0] done_mask;
   logic [NUM_CH-1:0] ovf_mask;

   logic              s_rd_valid;
   logic [SAT_W-1:0]  s_rd_data;
   logic [EVT_W-1:0]  s_rd_evt;
   logic [NUM_CH-1:0] s_done;
   logic [NUM_CH-1:0] s_ovf;

   flag_cycle_counter_mc #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .EVT_W(EVT_W), .SYNC_STAGES(SYNC_STAGES), .SEL_W(SEL_W)
   ) u_dut (
      .clock(clock), .rstb(rstb), .flag_in(flag_in), .mode(mode), .clear(clear),
      .rd_en(rd_en), .ch_sel(ch_sel), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_evt(rd_evt), .done_mask(done_mask), .ovf_mask(ovf_mask)
   );

   // Narrow-counter instance sharing the same stimulus, used for the saturation checks.
   flag_cycle_counter_mc #(
      .NUM_CH(NUM_CH), .CNT_W(SAT_W), .EVT_W(EVT_W), .SYNC_STAGES(SYNC_STAGES), .SEL_W(SEL_W)
   ) u_sat (
      .clock(clock), .rstb(rstb), .flag_in(flag_in), .mode(mode), .clear(clear),
      .rd_en(rd_en), .ch_sel(ch_sel), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
      .rd_evt(s_rd_evt), .done_mask(s_done), .ovf_mask(s_ovf)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks high-cycle counts and rise timestamps per channel.
   logic [NUM_CH-1:0] m_pipe[$];
   logic [NUM_CH-1:0] m_prev;
   longint            m_high [NUM_CH];
   longint            m_last [NUM_CH];
   longint            m_cap  [NUM_CH];
   int                m_evt  [NUM_CH];
   bit                m_armed[NUM_CH];
   logic [NUM_CH-1:0] m_done, m_ovf;
   bit                m_rv;
   longint            m_rd;
   int                m_re;
   longint            m_k = 0;

   function automatic void model_clear();
      for (int c = 0; c < int'(NUM_CH); c++) begin
         m_high[c] = 0; m_last[c] = 0; m_cap[c] = 0; m_evt[c] = 0; m_armed[c] = 0;
      end
      m_done = '0;
      m_ovf  = '0;
   endfunction

   function automatic void model_reset();
      m_pipe.delete();
      for (int s = 0; s < int'(SYNC_STAGES); s++) m_pipe.push_back('0);
      m_prev = '0;
      model_clear();
      m_rv = 0; m_rd = 0; m_re = 0;
   endfunction

   function automatic longint sat(input longint v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic void model_step();
      logic [NUM_CH-1:0] fs, cap_now;
      m_k++;
      fs = (m_pipe.size() == 0) ? flag_in : m_pipe[0];
      cap_now = '0;
      if (rd_en) begin
         m_rv = 1;
         if (ch_sel < NUM_CH) begin
            m_rd = m_cap[ch_sel];
            m_re = m_evt[ch_sel];
         end else begin
            m_rd = 0;
            m_re = 0;
         end
      end else begin
         m_rv = 0;
      end
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (!mode[c]) begin
            if (fs[c]) begin
               m_high[c]++;
               if (m_high[c] > CMAX) m_ovf[c] = 1'b1;
            end
            if (!fs[c] && m_prev[c]) begin
               m_cap[c] = sat(m_high[c]);
               m_high[c] = 0;
               m_evt[c] = (m_evt[c] + 1) % (1 << EVT_W);
               m_done[c] = 1'b1;
               cap_now[c] = 1'b1;
            end
         end else if (fs[c] && !m_prev[c]) begin
            if (m_armed[c]) begin
               m_cap[c] = sat(m_k - m_last[c]);
               m_evt[c] = (m_evt[c] + 1) % (1 << EVT_W);
               m_done[c] = 1'b1;
               cap_now[c] = 1'b1;
            end
            m_armed[c] = 1;
            m_last[c]  = m_k;
         end else if (m_armed[c] && (m_k - m_last[c]) >= CMAX) begin
            m_ovf[c] = 1'b1;
         end
      end
      if (rd_en && ch_sel < NUM_CH && !cap_now[ch_sel]) m_done[ch_sel] = 1'b0;
      if (clear) model_clear();
      m_prev = fs;
      m_pipe.push_back(flag_in);
      void'(m_pipe.pop_front());
   endfunction

   task automatic tick();
      if (rstb) model_step();
      @(posedge clock);
      #1;
      chk("model rd_valid", 64'(rd_valid), 64'(m_rv));
      chk("model rd_data", 64'(rd_data), 64'(m_rd));
      chk("model rd_evt", 64'(rd_evt), 64'(m_re));
      chk("model done_mask", 64'(done_mask), 64'(m_done));
      chk("model ovf_mask", 64'(ovf_mask), 64'(m_ovf));
   endtask

   task automatic pulse(input int ch, input int len);
      flag_in[ch] = 1'b1;
      repeat (len) tick();
      flag_in[ch] = 1'b0;
   endtask

   task automatic do_read(input int ch, input longint exp_d, input int exp_e, input string nm);
      rd_en  = 1'b1;
      ch_sel = SEL_W'(ch);
      tick();
      rd_en  = 1'b0;
      chk({nm, " rd_valid"}, 64'(rd_valid), 64'(1));
      chk({nm, " rd_data"}, 64'(rd_data), 64'(exp_d));
      chk({nm, " rd_evt"}, 64'(rd_evt), 64'(exp_e));
   endtask

   typedef struct {
      int     ch;
      int     len;
      longint exp_data;
      int     exp_evt;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{ch: 0, len: 37,  exp_data: 37,  exp_evt: 1};
      tbl[1] = '{ch: 0, len: 5,   exp_data: 5,   exp_evt: 2};
      tbl[2] = '{ch: 1, len: 1,   exp_data: 1,   exp_evt: 1};
      tbl[3] = '{ch: 1, len: 64,  exp_data: 64,  exp_evt: 2};
      tbl[4] = '{ch: 3, len: 200, exp_data: 200, exp_evt: 1};
      tbl[5] = '{ch: 0, len: 2,   exp_data: 2,   exp_evt: 3};

      // Reset held with toggling flags.
      model_reset();
      repeat (10) begin
         flag_in = NUM_CH'($urandom);
         tick();
      end
      flag_in = '0;
      rstb = 1'b1;
      tick();
      chk("reset done_mask", 64'(done_mask), 64'(0));
      chk("reset ovf_mask", 64'(ovf_mask), 64'(0));
      chk("reset rd_valid", 64'(rd_valid), 64'(0));
      do_read(0, 0, 0, "reset read");

      // High-time vectors, including the three-cycle done latency.
      foreach (tbl[v]) begin
         pulse(tbl[v].ch, tbl[v].len);
         tick(); tick();
         chk($sformatf("vec%0d done early", v), 64'(done_mask[tbl[v].ch]), 64'(0));
         tick();
         chk($sformatf("vec%0d done set", v), 64'(done_mask[tbl[v].ch]), 64'(1));
         do_read(tbl[v].ch, tbl[v].exp_data, tbl[v].exp_evt, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d done cleared", v), 64'(done_mask[tbl[v].ch]), 64'(0));
      end

      // Saturation on the narrow instance.
      clear = 1'b1; tick(); clear = 1'b0;
      pulse(1, 20);
      repeat (3) tick();
      chk("sat ovf set", 64'(s_ovf[1]), 64'(1));
      do_read(1, 20, 1, "sat wide");
      chk("sat rd_data", 64'(s_rd_data), 64'(15));
      clear = 1'b1; tick(); clear = 1'b0;
      chk("sat ovf cleared", 64'(s_ovf[1]), 64'(0));
      do_read(1, 0, 0, "sat after clear");
      chk("sat rd_data cleared", 64'(s_rd_data), 64'(0));

      // Period mode on ch2: rises at t0, t0+100, t0+250.
      mode[2] = 1'b1;
      clear = 1'b1; tick(); clear = 1'b0;
      pulse(2, 3);
      repeat (97) tick();
      chk("period no first capture", 64'(done_mask[2]), 64'(0));
      pulse(2, 3);
      repeat (7) tick();
      chk("period done", 64'(done_mask[2]), 64'(1));
      do_read(2, 100, 1, "period first");
      repeat (139) tick();
      pulse(2, 3);
      repeat (7) tick();
      do_read(2, 150, 2, "period second");
      mode[2] = 1'b0;
      clear = 1'b1; tick(); clear = 1'b0;

      // Capture and read of ch3 on the same edge.
      pulse(3, 7);
      repeat (3) tick();
      pulse(3, 11);
      tick(); tick();
      rd_en = 1'b1; ch_sel = 3; tick(); rd_en = 1'b0;
      chk("coll rd_valid", 64'(rd_valid), 64'(1));
      chk("coll rd_data old", 64'(rd_data), 64'(7));
      chk("coll rd_evt old", 64'(rd_evt), 64'(1));
      chk("coll done kept", 64'(done_mask[3]), 64'(1));
      do_read(3, 11, 2, "coll new");

      // Clear and read on the same edge return pre-clear values.
      rd_en = 1'b1; ch_sel = 3; clear = 1'b1; tick(); rd_en = 1'b0; clear = 1'b0;
      chk("clr+rd rd_valid", 64'(rd_valid), 64'(1));
      chk("clr+rd rd_data", 64'(rd_data), 64'(11));
      chk("clr+rd done", 64'(done_mask), 64'(0));

      // Clear coincident with a fall loses the episode.
      pulse(0, 6);
      tick(); tick();
      clear = 1'b1; tick(); clear = 1'b0;
      chk("clr+fall done", 64'(done_mask[0]), 64'(0));
      repeat (3) tick();
      chk("clr+fall done later", 64'(done_mask), 64'(0));
      do_read(0, 0, 0, "clr+fall read");

      // Out-of-range select and output hold.
      pulse(1, 9);
      repeat (3) tick();
      do_read(1, 9, 1, "pre oor");
      tick();
      chk("hold rd_valid", 64'(rd_valid), 64'(0));
      chk("hold rd_data", 64'(rd_data), 64'(9));
      do_read(NUM_CH, 0, 0, "oor");
      chk("oor done untouched", 64'(done_mask), 64'(0));

      // Asynchronous reset mid-episode.
      pulse(2, 4);
      repeat (3) tick();
      do_read(1, 9, 1, "pre areset");
      flag_in[0] = 1'b1;
      repeat (14) tick();
      rstb = 1'b0;
      model_reset();
      #1;
      chk("areset rd_valid", 64'(rd_valid), 64'(0));
      chk("areset rd_data", 64'(rd_data), 64'(0));
      chk("areset rd_evt", 64'(rd_evt), 64'(0));
      chk("areset done_mask", 64'(done_mask), 64'(0));
      chk("areset ovf_mask", 64'(ovf_mask), 64'(0));
      flag_in[0] = 1'b0;
      repeat (3) tick();
      rstb = 1'b1;
      tick();
      pulse(0, 9);
      repeat (3) tick();
      do_read(0, 9, 1, "post areset");

      // Randomized segments against the model.
      for (int seg = 0; seg < 3; seg++) begin
         int unsigned tog;
         tog = 2 + seg * 10;
         mode  = NUM_CH'($urandom);
         clear = 1'b1; tick(); clear = 1'b0;
         repeat (1500) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
               if ($urandom_range(tog - 1, 0) == 0) flag_in[c] = ~flag_in[c];
            end
            rd_en  = ($urandom_range(3, 0) == 0);
            ch_sel = SEL_W'($urandom_range(7, 0));
            clear  = ($urandom_range(299, 0) == 0);
            tick();
         end
         rd_en = 1'b0;
         clear = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_cycle_counter_mc.md
Name: flag_cycle_counter_mc

Overview:
- Parametrised multi-channel successor to the single GPIO-flag cycle counter used in the accelerator benches.
- Counts cycles per channel from flags driven by the user project (e.g. mprj_io[20] "busy" strobes).
- Captures a result per flag episode, with saturation, overflow flags and event counts.
- Exposes results through a registered read port so firmware or a bench can poll latency and throughput of several accelerator units at once.

Parameters:
- NUM_CH, 4, number of independent flag channels (1..16).
- CNT_W, 33, width of the live and captured cycle counters.
- EVT_W, 8, width of the per-channel episode counter; wraps.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each flag input (0 = no synchronizer, flag used directly).
- SEL_W, 4, width of the channel select; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clock  in  1  single system clock, rising edge.
- rstb  in  1  asynchronous active-low reset.
- flag_in  in  NUM_CH  raw per-channel flags.
- mode  in  NUM_CH  per channel: 0 = high-time mode, 1 = period mode (rising-to-rising).
- clear  in  1  synchronous pulse; clears all counters, capture registers and sticky flags.
- rd_en  in  1  read request pulse.
- ch_sel  in  SEL_W  channel selected for the read.
- rd_valid  out  1  read result valid; one-cycle pulse.
- rd_data  out  CNT_W  captured cycle count of the selected channel.
- rd_evt  out  EVT_W  episode count of the selected channel.
- done_mask  out  NUM_CH  sticky "new capture available" per channel.
- ovf_mask  out  NUM_CH  sticky "live counter saturated" per channel.

Behaviour:
- Reset (rstb low, asynchronous): all synchronizer stages, the previous-flag register, live, captured, evt, armed, done_mask, ovf_mask, rd_valid, rd_data and rd_evt go to 0 immediately. Logic is released on the first rising clock edge with rstb high.
- Synchronization and edges:
  - flag_s = flag_in delayed by SYNC_STAGES cycles.
  - rise = flag_s & ~flag_prev; fall = ~flag_s & flag_prev.
- Mode 0 (high time):
  - Each cycle with flag_s = 1: live += 1.
  - On fall: captured <= live, live <= 0, evt += 1, done set.
  - Result: a flag high for N synchronized cycles captures exactly N.
- Mode 1 (period):
  - First rise after reset or clear: armed <= 1, live <= 1, no capture.
  - Subsequent rise: captured <= live, live <= 1, evt += 1, done set.
  - While armed and not on a rise: live += 1 every cycle.
  - Result: a rise-to-rise spacing of P cycles captures P.
- Saturation: live never wraps. An increment at all-ones holds all-ones and sets the channel's ovf bit. ovf is sticky until clear. A capture of a saturated live value reports all-ones.
- evt wraps modulo 2**EVT_W and never sets ovf.
- Mode change: sampled every cycle. Changing mode mid-episode is undefined; firmware issues clear after any mode change.
- Read:
  - Read latency is 1 cycle: rd_en with ch_sel registered -> next cycle rd_valid = 1 with rd_data = captured[ch_sel] and rd_evt = evt[ch_sel].
  - The same edge clears done_mask[ch_sel] (read-to-clear).
  - ch_sel >= NUM_CH: rd_valid = 1, rd_data = 0, rd_evt = 0, no side effects.
  - rd_data and rd_evt hold their value when rd_valid = 0.
- Simultaneous events:
  - Capture and read of the same channel on the same edge: rd_data returns the pre-capture value, and done remains set (capture wins over read-clear).
  - clear and capture on the same edge: clear wins; all state is zeroed, the episode is lost, and armed = 0.
  - clear and rd_en on the same edge: the read returns pre-clear values; rd_valid still pulses.
- The flag synchronizers are not affected by clear, so an edge in flight is still seen after clear. In mode 0, a flag already high at clear counts from the following cycle.

Test Plan:
- Reset/idle: hold rstb = 0 for 10 cycles with flags toggling, then release -> done_mask = 0, ovf_mask = 0, rd_valid = 0; reading ch 0 gives rd_data = 0, rd_evt = 0.
- Mode 0, SYNC_STAGES = 2:
  - Ch0 flag high 37 cycles -> done_mask[0] = 1 three cycles after the fall; read ch0 -> rd_valid one cycle after rd_en, rd_data = 37, rd_evt = 1, done_mask[0] cleared.
  - A second 5-cycle pulse -> rd_data = 5, rd_evt = 2.
- Mode 1: ch2 rises at t0, t0+100, t0+250 -> first capture 100, second 150, evt = 2. No capture on the first rise.
- Saturation: CNT_W = 4; hold ch1 high 20 cycles -> rd_data = 15, ovf_mask[1] = 1; issue clear -> ovf_mask[1] = 0, rd_data = 0.
- Collisions:
  - Fall on ch3 on the same edge as rd_en ch3 -> rd_data = old value, done_mask[3] stays 1.
  - clear coincident with a fall -> evt unchanged at 0, done = 0.
  - ch_sel = NUM_CH -> rd_data = 0, rd_valid = 1.
- Async reset mid-episode: drop rstb while ch0 has live = 12 -> all outputs 0 within the same cycle. After release, a 9-cycle pulse captures 9, not 21.
